// File: rtl/ext_bus_scheduler_pkg.sv
// rtl/ext_bus_scheduler_pkg.sv - shared types and constants for the external bus scheduler
package ext_bus_pkg;

    localparam int BUS_W  = 8;
    localparam int WAIT_W = 2;

    localparam logic [BUS_W-1:0] EN_ALL  = 8'hFF;
    localparam logic [BUS_W-1:0] EN_NONE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_TURN = 3'd2,
        ST_DATA = 3'd3,
        ST_ACK  = 3'd4
    } ebs_state_t;

endpackage

// File: rtl/ext_bus_scheduler_if.sv
// rtl/ext_bus_scheduler_if.sv - requester handshakes and bus pins of the external bus scheduler
interface ext_bus_scheduler_if #(
    parameter int BUS_W  = 8,
    parameter int WAIT_W = 2
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [BUS_W-1:0]  addr0;
    logic [BUS_W-1:0]  addr1;
    logic [BUS_W-1:0]  wdata0;
    logic [BUS_W-1:0]  wdata1;
    logic [WAIT_W-1:0] wait_cfg;
    logic              ack0;
    logic              ack1;
    logic [BUS_W-1:0]  rdata;
    logic              grant;
    logic              busy;
    logic [BUS_W-1:0]  bus_in;
    logic [BUS_W-1:0]  bus_out;
    logic [BUS_W-1:0]  bus_en;
    logic              ale;

    // Requesters and pin pads: drive requests and bus_in, observe everything else.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wait_cfg, bus_in,
        input  ack0, ack1, rdata, grant, busy, bus_out, bus_en, ale
    );

    // The scheduler itself.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, wait_cfg, bus_in,
        output ack0, ack1, rdata, grant, busy, bus_out, bus_en, ale
    );

endinterface

// File: rtl/ext_bus_scheduler_rr_arbiter2.sv
// rtl/ext_bus_scheduler_rr_arbiter2.sv - two-port round-robin arbiter with a last-served flop
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    input  logic served,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last;

    // Remember who completed most recently; reset favours port 0 on the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (advance) begin
            last <= served;
        end
    end

    // A lone request wins outright; a tie goes to the port not served last.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = (req0 && req1) ? ~last : req1;
    end

endmodule

// File: rtl/ext_bus_scheduler.sv
// rtl/ext_bus_scheduler.sv - arbitrates and sequences transactions on the multiplexed external bus
module ext_bus_scheduler #(
    parameter int BUS_W  = 8,
    parameter int WAIT_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    ext_bus_scheduler_if.slave  io
);

    import ext_bus_pkg::*;

    localparam logic [WAIT_W-1:0] CNT_ZERO = '0;
    localparam logic [WAIT_W-1:0] CNT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

    ebs_state_t        state;
    ebs_state_t        state_nx;

    logic              owner;
    logic              we_q;
    logic [BUS_W-1:0]  addr_q;
    logic [BUS_W-1:0]  wdata_q;
    logic [BUS_W-1:0]  rdata_q;
    logic [WAIT_W-1:0] cnt;

    logic              arb_valid;
    logic              arb_id;
    logic              advance;
    logic              grant_edge;
    logic              data_last;

    logic              ale_c;
    logic              ack0_c;
    logic              ack1_c;
    logic [BUS_W-1:0]  bus_out_c;
    logic [BUS_W-1:0]  bus_en_c;

    assign advance    = (state == ST_ACK);
    assign grant_edge = (state == ST_IDLE) && arb_valid;
    assign data_last  = (state == ST_DATA) && (cnt == CNT_ZERO);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req0      (io.req0),
        .req1      (io.req1),
        .advance   (advance),
        .served    (owner),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Latch the winner's transaction on the grant edge, count down wait states, capture read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (grant_edge) begin
                owner   <= arb_id;
                we_q    <= arb_id ? io.we1    : io.we0;
                addr_q  <= arb_id ? io.addr1  : io.addr0;
                wdata_q <= arb_id ? io.wdata1 : io.wdata0;
                cnt     <= io.wait_cfg;
            end else if (state == ST_DATA && cnt != CNT_ZERO) begin
                cnt <= cnt - CNT_ONE;
            end
            if (data_last && !we_q) begin
                rdata_q <= io.bus_in;
            end
        end
    end

    // Next-state sequencing: one transaction is ADDR, TURN, cnt+1 DATA cycles, ACK.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (arb_valid) state_nx = ST_ADDR;
            ST_ADDR: state_nx = ST_TURN;
            ST_TURN: state_nx = ST_DATA;
            ST_DATA: if (cnt == CNT_ZERO) state_nx = ST_ACK;
            ST_ACK:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Moore pin and ack decode from the state and latched transaction only.
    always_comb begin
        ale_c     = 1'b0;
        ack0_c    = 1'b0;
        ack1_c    = 1'b0;
        bus_out_c = '0;
        bus_en_c  = EN_NONE;
        case (state)
            ST_ADDR: begin
                ale_c     = 1'b1;
                bus_out_c = addr_q;
                bus_en_c  = EN_ALL;
            end
            ST_TURN, ST_DATA: begin
                if (we_q) begin
                    bus_out_c = wdata_q;
                    bus_en_c  = EN_ALL;
                end
            end
            ST_ACK: begin
                ack0_c = ~owner;
                ack1_c = owner;
            end
            default: ;
        endcase
    end

    assign io.ale     = ale_c;
    assign io.ack0    = ack0_c;
    assign io.ack1    = ack1_c;
    assign io.bus_out = bus_out_c;
    assign io.bus_en  = bus_en_c;
    assign io.rdata   = rdata_q;
    assign io.grant   = owner;
    assign io.busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_ext_bus_scheduler.sv
// tb/tb_ext_bus_scheduler.sv - directed self-checking bench for ext_bus_scheduler
module tb_ext_bus_scheduler;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    ext_bus_scheduler_if #(.BUS_W(8), .WAIT_W(2)) io ();

    ext_bus_scheduler #(.BUS_W(8), .WAIT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        io.req0     = 1'b0;
        io.req1     = 1'b0;
        io.we0      = 1'b0;
        io.we1      = 1'b0;
        io.addr0    = 8'h00;
        io.addr1    = 8'h00;
        io.wdata0   = 8'h00;
        io.wdata1   = 8'h00;
        io.wait_cfg = 2'd0;
        io.bus_in   = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_ale", io.ale, 0);
        chk("rst_en", io.bus_en, 8'h00);
        chk("rst_out", io.bus_out, 8'h00);
        chk("rst_ack0", io.ack0, 0);
        chk("rst_ack1", io.ack1, 0);
        chk("rst_rdata", io.rdata, 8'h00);
        chk("rst_busy", io.busy, 0);
        chk("rst_grant", io.grant, 0);
        rst = 1'b0;

        // Read from port 1 with wait_cfg=2: data phase cycles 3..5, ack at cycle 6
        io.req1 = 1'b1; io.we1 = 1'b0; io.addr1 = 8'h10; io.wait_cfg = 2'd2; io.bus_in = 8'h11;
        tick();
        chk("rd_ale", io.ale, 1);
        chk("rd_addr", io.bus_out, 8'h10);
        chk("rd_addr_en", io.bus_en, 8'hFF);
        chk("rd_grant", io.grant, 1);
        io.req1 = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("rd_en_released", io.bus_en, 8'h00);
            chk("rd_ale_low", io.ale, 0);
            chk("rd_no_early_ack", io.ack1, 0);
            if (c == 5) io.bus_in = 8'h5E;
        end
        tick();
        chk("rd_ack1", io.ack1, 1);
        chk("rd_ack0_quiet", io.ack0, 0);
        chk("rd_rdata", io.rdata, 8'h5E);
        chk("rd_grant_ack", io.grant, 1);
        chk("rd_ack_en", io.bus_en, 8'h00);
        io.bus_in = 8'h00;
        tick();
        chk("rd_ack_pulse", io.ack1, 0);
        chk("rd_rdata_hold", io.rdata, 8'h5E);
        chk("rd_idle", io.busy, 0);

        // Write from port 0 with wait_cfg=0: ack at cycle 4
        io.req0 = 1'b1; io.we0 = 1'b1; io.addr0 = 8'h3C; io.wdata0 = 8'hA5; io.wait_cfg = 2'd0;
        tick();
        chk("wr_ale", io.ale, 1);
        chk("wr_addr", io.bus_out, 8'h3C);
        chk("wr_addr_en", io.bus_en, 8'hFF);
        chk("wr_grant", io.grant, 0);
        chk("wr_busy", io.busy, 1);
        io.req0 = 1'b0;
        tick();
        chk("wr_turn_ale", io.ale, 0);
        chk("wr_turn_data", io.bus_out, 8'hA5);
        chk("wr_turn_en", io.bus_en, 8'hFF);
        tick();
        chk("wr_data", io.bus_out, 8'hA5);
        chk("wr_no_early_ack", io.ack0, 0);
        tick();
        chk("wr_ack0", io.ack0, 1);
        chk("wr_ack1_quiet", io.ack1, 0);
        chk("wr_ack_en", io.bus_en, 8'h00);
        tick();
        chk("wr_ack_pulse", io.ack0, 0);
        chk("wr_rdata_kept", io.rdata, 8'h5E);
        chk("wr_idle", io.busy, 0);

        // Both ports held high after reset: grants 0,1,0 with acks at cycles 4, 9, 14
        rst = 1'b1;
        tick();
        rst = 1'b0;
        io.req0 = 1'b1; io.req1 = 1'b1; io.we0 = 1'b1; io.we1 = 1'b1;
        io.addr0 = 8'h01; io.addr1 = 8'h02; io.wait_cfg = 2'd0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk("rr_ack0", io.ack0, (c == 4 || c == 14) ? 1 : 0);
            chk("rr_ack1", io.ack1, (c == 9) ? 1 : 0);
            if (c == 1 || c == 6 || c == 11) begin
                chk("rr_grant", io.grant, (c == 6) ? 1 : 0);
                chk("rr_addr", io.bus_out, (c == 6) ? 8'h02 : 8'h01);
            end
            if (c == 14) begin
                io.req0 = 1'b0;
                io.req1 = 1'b0;
            end
        end
        tick();
        chk("rr_idle", io.busy, 0);
        chk("rr_rdata_reset", io.rdata, 8'h00);

        // Reset in the data phase of a write: pins released at once, no ack afterwards
        io.req0 = 1'b1; io.we0 = 1'b1; io.addr0 = 8'h44; io.wdata0 = 8'h5A; io.wait_cfg = 2'd3;
        tick();
        io.req0 = 1'b0;
        tick();
        tick();
        chk("ab_data_en", io.bus_en, 8'hFF);
        chk("ab_data_out", io.bus_out, 8'h5A);
        #3;
        rst = 1'b1;
        #1;
        chk("ab_en", io.bus_en, 8'h00);
        chk("ab_ale", io.ale, 0);
        chk("ab_out", io.bus_out, 8'h00);
        chk("ab_busy", io.busy, 0);
        chk("ab_ack0", io.ack0, 0);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("ab_no_ack", io.ack0, 0);
            chk("ab_stay_idle", io.busy, 0);
        end
        io.req0 = 1'b1; io.we0 = 1'b0; io.addr0 = 8'h21; io.wait_cfg = 2'd0; io.bus_in = 8'hC3;
        tick();
        chk("ab_next_ale", io.ale, 1);
        chk("ab_next_addr", io.bus_out, 8'h21);
        chk("ab_next_grant", io.grant, 0);
        io.req0 = 1'b0;
        tick();
        tick();
        tick();
        chk("ab_next_ack", io.ack0, 1);
        chk("ab_next_rdata", io.rdata, 8'hC3);
        tick();

        // Late changes to wait_cfg/addr0 affect only the following transaction
        io.req0 = 1'b1; io.we0 = 1'b1; io.addr0 = 8'h3C; io.wdata0 = 8'h77; io.wait_cfg = 2'd0;
        tick();
        io.wait_cfg = 2'd3;
        io.addr0    = 8'h99;
        chk("lt_ale", io.ale, 1);
        chk("lt_addr_orig", io.bus_out, 8'h3C);
        for (int c = 2; c <= 12; c++) begin
            tick();
            chk("lt_ack0", io.ack0, (c == 4 || c == 12) ? 1 : 0);
            if (c == 2 || c == 3) chk("lt_wdata", io.bus_out, 8'h77);
            if (c == 6) begin
                chk("lt_next_ale", io.ale, 1);
                chk("lt_next_addr", io.bus_out, 8'h99);
                io.req0 = 1'b0;
            end
        end
        tick();
        chk("lt_idle", io.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
